// File: rtl/priority_encoder_4to2_pkg.sv
// Shared types and helpers for the registered 4-to-2 priority encoder.
package prio_enc_pkg;

  localparam int N_REQ  = 4;
  localparam int CODE_W = 2;

  typedef logic [N_REQ-1:0]  req_t;
  typedef logic [CODE_W-1:0] code_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  function automatic logic [2:0] popcount4(req_t v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/priority_encoder_4to2_if.sv
// Request-in / code-out handshake bundle of the priority encoder.
interface prio_enc_if;
  import prio_enc_pkg::*;

  req_t  d;
  logic  d_valid;
  logic  d_ready;
  code_t y;
  logic  y_valid;
  logic  y_ready;
  logic  multi;
  logic  err;

  modport slave (
    input  d, d_valid, y_ready,
    output d_ready, y, y_valid, multi, err
  );

  modport master (
    output d, d_valid, y_ready,
    input  d_ready, y, y_valid, multi, err
  );

endinterface

// File: rtl/priority_encoder_4to2_pick.sv
// Combinational winner search: scans downward from `start` with wrap-around.
module enc_prio_pick
  import prio_enc_pkg::*;
(
  input  req_t  req,
  input  code_t start,
  output code_t win,
  output logic  any
);

  code_t idx;

  always_comb begin
    win = '0;
    any = 1'b0;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = start - code_t'(i);
      if (!any && req[idx]) begin
        win = idx;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/priority_encoder_4to2.sv
// Registered 4-to-2 priority encoder with valid/ready handshake.
// Optional rotating priority is enabled by defining PRIO_ENC_ROUND_ROBIN_EN.
module priority_encoder_4to2 #(
  parameter int N_REQ  = 4,
  parameter int CODE_W = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  prio_enc_if.slave      bus
);
  import prio_enc_pkg::*;

  generate
    if (N_REQ != 4 || CODE_W != $clog2(N_REQ)) begin : g_bad_cfg
      $error("priority_encoder_4to2 supports only N_REQ=4, CODE_W=2");
    end
  endgenerate

  state_t state_p1;
  state_t state_nxt;
  code_t  y_p1;
  logic   multi_p1;
  logic   err_p1;
  code_t  start;
  code_t  win;
  logic   any;
  logic   xfer_in;
  logic   xfer_out;
  logic   load;

  assign bus.y_valid = (state_p1 == FULL);
  assign bus.d_ready = !bus.y_valid || bus.y_ready;
  assign bus.y       = y_p1;
  assign bus.multi   = multi_p1;
  assign bus.err     = err_p1;

  assign xfer_in  = bus.d_valid && bus.d_ready;
  assign xfer_out = bus.y_valid && bus.y_ready;
  assign load     = xfer_in && any;

  enc_prio_pick u_pick (
    .req   (bus.d),
    .start (start),
    .win   (win),
    .any   (any)
  );

`ifdef PRIO_ENC_ROUND_ROBIN_EN
  code_t ptr_p1;

  // Last winner drops to lowest priority; reset value 3 matches fixed priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_p1 <= code_t'(N_REQ - 1);
    end else if (load) begin
      ptr_p1 <= win - code_t'(1);
    end
  end

  assign start = ptr_p1;
`else
  assign start = code_t'(N_REQ - 1);
`endif

  always_comb begin
    state_nxt = state_p1;
    case (state_p1)
      EMPTY:   if (load) state_nxt = FULL;
      FULL:    if (xfer_out && !load) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1 <= EMPTY;
    end else begin
      state_p1 <= state_nxt;
    end
  end

  // Stage p1: output code register, loaded only by a nonzero transfer-in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_p1     <= '0;
      multi_p1 <= 1'b0;
      err_p1   <= 1'b0;
    end else begin
      err_p1 <= xfer_in && !any;
      if (load) begin
        y_p1     <= win;
        multi_p1 <= (popcount4(bus.d) > 3'd1);
      end
    end
  end

endmodule
